hier_node_ctrl: RTL and testbench

//  Parametrised hierarchy-node controller: one parent-side start/done handshake fanned out to NUM_CHILDREN child blocks.

---
 rtl/hier_node_if.sv | 28 ++
 rtl/hier_node_ctrl.sv | 153 +++++++++++++++
 tb/tb_hier_node_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hier_node_if.sv
// Parent/child handshake bundle of one hierarchy-node controller.
// The controller connects through the slave view; the upstream driver uses the master view.
interface hier_node_if #(
  parameter int NUM_CHILDREN = 5,
  parameter int CNT_W        = 16
);
  logic                    parent_start;
  logic                    seq_mode;
  logic [NUM_CHILDREN-1:0] child_en;
  logic [CNT_W-1:0]        timeout_cycles;
  logic                    parent_busy;
  logic                    parent_done;
  logic                    parent_err;
  logic [NUM_CHILDREN-1:0] child_start;
  logic [NUM_CHILDREN-1:0] child_done;
  logic [NUM_CHILDREN-1:0] done_mask;
  logic [CNT_W-1:0]        elapsed;

  modport slave (
    input  parent_start, seq_mode, child_en, timeout_cycles, child_done,
    output parent_busy, parent_done, parent_err, child_start, done_mask, elapsed
  );

  modport master (
    output parent_start, seq_mode, child_en, timeout_cycles, child_done,
    input  parent_busy, parent_done, parent_err, child_start, done_mask, elapsed
  );
endinterface

// File: rtl/hier_node_ctrl.sv
// Hierarchy-node controller: fans one parent start/done handshake out to NUM_CHILDREN
// child blocks, in parallel or in index order, gathering completions under a timeout.
module hier_node_ctrl #(
  parameter int NUM_CHILDREN = 5,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  hier_node_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_WAIT     = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ZERO  = '0;
  localparam logic [NUM_CHILDREN-1:0] MASK_ONE  = NUM_CHILDREN'(1);
  localparam logic [NUM_CHILDREN-1:0] MASK_ZERO = '0;

  // Sequential dispatch always picks the lowest-index pending child.
  function automatic logic [NUM_CHILDREN-1:0] lowest_bit(input logic [NUM_CHILDREN-1:0] m);
    return m & (~m + MASK_ONE);
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_CHILDREN-1:0] en_q, en_d;
  logic [NUM_CHILDREN-1:0] started_q, started_d;
  logic [NUM_CHILDREN-1:0] done_mask_q, done_mask_d;
  logic [NUM_CHILDREN-1:0] child_start_q, child_start_d;
  logic                    seq_q, seq_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]        elapsed_q, elapsed_d;
  logic [NUM_CHILDREN-1:0] accepted_s;
  logic                    start_acc_s;
  logic                    complete_s;
  logic                    timeout_s;

  // A done only counts for an enabled child started in an earlier cycle and not yet done.
  assign start_acc_s = (state_q == S_IDLE) && bus.parent_start;
  assign accepted_s  = (state_q == S_WAIT) ? (bus.child_done & en_q & started_q & ~done_mask_q)
                                           : MASK_ZERO;
  assign complete_s  = ((done_mask_q | accepted_s) == en_q);
  assign timeout_s   = (tmo_q != CNT_ZERO) && (elapsed_q == tmo_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = start_acc_s ? S_DISPATCH : S_IDLE;
      S_DISPATCH: state_d = S_WAIT;
      S_WAIT: begin
        if (complete_s) begin
          state_d = S_DONE;
        end else if (timeout_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Run context and next values of the registered outputs.
  always_comb begin
    en_d        = en_q;
    seq_d       = seq_q;
    tmo_d       = tmo_q;
    started_d   = started_q | child_start_q;
    done_mask_d = done_mask_q | accepted_s;
    elapsed_d   = elapsed_q;
    if (start_acc_s) begin
      en_d        = bus.child_en;
      seq_d       = bus.seq_mode;
      tmo_d       = bus.timeout_cycles;
      started_d   = MASK_ZERO;
      done_mask_d = MASK_ZERO;
      elapsed_d   = CNT_ZERO;
    end else if (((state_q == S_DISPATCH) || (state_q == S_WAIT)) && (elapsed_q != CNT_MAX)) begin
      elapsed_d = elapsed_q + CNT_ONE;
    end else begin
      elapsed_d = elapsed_q;
    end

    busy_d = (state_d == S_DISPATCH) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);

    // In sequential mode the outstanding child's accepted done releases the next one.
    if (state_d == S_DISPATCH) begin
      child_start_d = seq_d ? lowest_bit(en_d) : en_d;
    end else if ((state_d == S_WAIT) && seq_q && (accepted_s != MASK_ZERO)) begin
      child_start_d = lowest_bit(en_q & ~started_d);
    end else begin
      child_start_d = MASK_ZERO;
    end
  end

  // Run context and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q          <= MASK_ZERO;
      seq_q         <= 1'b0;
      tmo_q         <= CNT_ZERO;
      started_q     <= MASK_ZERO;
      done_mask_q   <= MASK_ZERO;
      elapsed_q     <= CNT_ZERO;
      child_start_q <= MASK_ZERO;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      en_q          <= en_d;
      seq_q         <= seq_d;
      tmo_q         <= tmo_d;
      started_q     <= started_d;
      done_mask_q   <= done_mask_d;
      elapsed_q     <= elapsed_d;
      child_start_q <= child_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.parent_busy = busy_q;
  assign bus.parent_done = done_q;
  assign bus.parent_err  = err_q;
  assign bus.child_start = child_start_q;
  assign bus.done_mask   = done_mask_q;
  assign bus.elapsed     = elapsed_q;

endmodule

// File: tb/tb_hier_node_ctrl.sv
// Randomized bench for hier_node_ctrl: per-run event schedule derived from the
// dispatch/complete/timeout rules, compared against observed pulses and final state.
module tb_hier_node_ctrl;
  localparam int N    = 5;
  localparam int W    = 4;
  localparam int CMAX = (1 << W) - 1;
  localparam int INF  = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  hier_node_if #(.NUM_CHILDREN(N), .CNT_W(W)) bus ();
  hier_node_ctrl #(.NUM_CHILDREN(N), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One run: schedule predicted from the rules, children answered d[i] cycles after their start.
  task automatic run_one(input string tag, input logic [N-1:0] en, input logic sq,
                         input logic [W-1:0] tmo, input int d [N]);
    int t0, c_end, kto, e_end, s, exp_el;
    int es [N];
    int fin [N];
    int obs_s [N];
    int n_s [N];
    int obs_done, obs_err, n_done, n_err, busy_bad, both_hi;
    logic [N-1:0] exp_mask, obs_mask, noise;
    logic [W-1:0] obs_el;
    bit done_path;

    t0 = cyc;
    s  = t0 + 1;
    for (int i = 0; i < N; i++) begin
      es[i] = INF; fin[i] = INF; obs_s[i] = -1; n_s[i] = 0;
      if (en[i] && !sq) begin
        es[i]  = t0 + 1;
        fin[i] = (d[i] == 0) ? INF : t0 + 1 + d[i];
      end else if (en[i] && s != INF) begin
        es[i]  = s;
        fin[i] = (d[i] == 0) ? INF : s + d[i];
        s      = (fin[i] == INF) ? INF : fin[i] + 1;
      end
    end
    c_end = t0 + 2;
    for (int i = 0; i < N; i++) if (en[i] && fin[i] > c_end) c_end = fin[i];
    kto       = (tmo != 0) ? t0 + 1 + int'(tmo) : INF;
    done_path = (c_end <= kto);
    e_end     = done_path ? c_end + 1 : kto + 1;
    exp_el    = (e_end - 1 - t0 > CMAX) ? CMAX : e_end - 1 - t0;
    exp_mask  = '0;
    for (int i = 0; i < N; i++) if (en[i] && fin[i] < e_end) exp_mask[i] = 1'b1;

    obs_done = -1; obs_err = -1; n_done = 0; n_err = 0; busy_bad = 0; both_hi = 0;
    obs_mask = '0; obs_el = '0;
    bus.parent_start   = 1'b1;
    bus.seq_mode       = sq;
    bus.child_en       = en;
    bus.timeout_cycles = tmo;
    bus.child_done     = N'($urandom_range(0, (1 << N) - 1));

    while (cyc <= e_end && cyc < t0 + 200) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.child_start[i]) begin
          n_s[i]++;
          if (obs_s[i] < 0) obs_s[i] = cyc;
        end
      end
      if (bus.parent_done) begin n_done++; if (obs_done < 0) obs_done = cyc; end
      if (bus.parent_err)  begin n_err++;  if (obs_err < 0)  obs_err  = cyc; end
      if (bus.parent_done && bus.parent_err) both_hi++;
      if (bus.parent_busy != ((cyc > t0) && (cyc < e_end))) busy_bad++;
      if (cyc == e_end) begin obs_mask = bus.done_mask; obs_el = bus.elapsed; end

      bus.parent_start   = (cyc <= e_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.seq_mode       = 1'($urandom_range(0, 1));
      bus.child_en       = N'($urandom_range(0, (1 << N) - 1));
      bus.timeout_cycles = W'($urandom_range(0, CMAX));
      noise = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (obs_s[i] >= 0 && cyc > obs_s[i]) begin
          if (d[i] != 0 && cyc == obs_s[i] + d[i]) noise[i] = 1'b1;
          else if (d[i] == 0 || cyc < obs_s[i] + d[i]) noise[i] = 1'b0;
        end
      end
      bus.child_done = noise;
    end
    bus.child_done = '0;

    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s start_cyc[%0d]", tag, i), (obs_s[i] < 0) ? -1 : obs_s[i] - t0,
                (es[i] < e_end) ? es[i] - t0 : -1);
      check_val($sformatf("%s start_cnt[%0d]", tag, i), n_s[i], (es[i] < e_end) ? 1 : 0);
    end
    check_val({tag, " done_cyc"}, (obs_done < 0) ? -1 : obs_done - t0, done_path ? e_end - t0 : -1);
    check_val({tag, " err_cyc"}, (obs_err < 0) ? -1 : obs_err - t0, done_path ? -1 : e_end - t0);
    check_val({tag, " done_cnt"}, n_done, done_path ? 1 : 0);
    check_val({tag, " err_cnt"}, n_err, done_path ? 0 : 1);
    check_val({tag, " busy_bad_cycles"}, busy_bad, 0);
    check_val({tag, " done_and_err"}, both_hi, 0);
    check_val({tag, " done_mask"}, obs_mask, exp_mask);
    check_val({tag, " elapsed"}, obs_el, exp_el);
  endtask

  initial begin
    int dl [N];
    int t_h, pulses;
    logic [N-1:0] r_en;
    logic [W-1:0] r_tmo;
    logic r_sq;

    bus.parent_start = 1'b0; bus.seq_mode = 1'b0; bus.child_en = '0;
    bus.timeout_cycles = '0; bus.child_done = '0;
    rst = 1'b1;
    step(); step();
    check_val("rst busy", bus.parent_busy, 0);
    check_val("rst done", bus.parent_done, 0);
    check_val("rst err", bus.parent_err, 0);
    check_val("rst child_start", bus.child_start, 0);
    check_val("rst done_mask", bus.done_mask, 0);
    check_val("rst elapsed", bus.elapsed, 0);
    rst = 1'b0;
    step();

    dl = '{4, 2, 6, 3, 5};  run_one("par_all",   5'b11111, 1'b0, 4'd0,  dl);
    dl = '{2, 2, 2, 2, 2};  run_one("seq_10101", 5'b10101, 1'b1, 4'd0,  dl);
    dl = '{1, 1, 1, 1, 1};  run_one("empty_par", 5'b00000, 1'b0, 4'd0,  dl);
    dl = '{1, 1, 1, 1, 1};  run_one("empty_seq", 5'b00000, 1'b1, 4'd5,  dl);
    dl = '{1, 2, 3, 0, 4};  run_one("tmo_c3",    5'b11111, 1'b0, 4'd10, dl);
    dl = '{3, 1, 1, 1, 1};  run_one("tie",       5'b00001, 1'b0, 4'd3,  dl);
    dl = '{4, 4, 4, 4, 4};  run_one("seq_sat",   5'b11111, 1'b1, 4'd0,  dl);
    dl = '{4, 4, 4, 4, 4};  run_one("tmo_max",   5'b11111, 1'b1, 4'd15, dl);

    for (int r = 0; r < 30; r++) begin
      r_en  = N'($urandom_range(0, (1 << N) - 1));
      r_sq  = 1'($urandom_range(0, 1));
      r_tmo = ($urandom_range(0, 2) == 0) ? W'(0) : W'($urandom_range(1, CMAX));
      for (int i = 0; i < N; i++) dl[i] = (r_tmo == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
      repeat ($urandom_range(0, 2)) step();
      run_one($sformatf("rand%0d", r), r_en, r_sq, r_tmo, dl);
    end

    // Stalled run (child 0 never answers, no timeout), then reset mid-WAIT.
    bus.parent_start = 1'b1; bus.child_en = 5'b00001; bus.seq_mode = 1'b0;
    bus.timeout_cycles = '0; bus.child_done = '0;
    t_h = cyc;
    while (cyc < t_h + 20) begin
      step();
      bus.parent_start = 1'($urandom_range(0, 1));
      bus.child_done   = N'($urandom_range(0, (1 << N) - 1)) & 5'b11110;
    end
    check_val("hang busy", bus.parent_busy, 1);
    check_val("hang elapsed_sat", bus.elapsed, CMAX);
    check_val("hang done_mask", bus.done_mask, 0);
    rst = 1'b1;
    bus.parent_start = 1'b0;
    step();
    check_val("midrst busy", bus.parent_busy, 0);
    check_val("midrst child_start", bus.child_start, 0);
    check_val("midrst done_mask", bus.done_mask, 0);
    check_val("midrst elapsed", bus.elapsed, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      step();
      if (bus.parent_done || bus.parent_err || bus.parent_busy || (bus.child_start != 0)) pulses++;
    end
    check_val("postrst activity", pulses, 0);
    bus.child_done = '0;
    dl = '{1, 3, 2, 1, 1};  run_one("after_rst", 5'b00111, 1'b1, 4'd0, dl);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
